// File: rtl/arb_mux_n_to_1.sv
// Registered N-to-1 multiplexer with internal fixed-priority or round-robin arbitration
// and valid/ready handshakes on every input channel and on the single output.
module arb_mux_n_to_1 #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 4,
  parameter int SEL_W   = 2,
  parameter int RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load;
  logic              found;
  logic [SEL_W-1:0]  gsel;
  logic [NUM_IN-1:0] grant;
  logic [WIDTH-1:0]  gdata;

  // Round-robin is two passes: first valid at or above rr_ptr, else lowest valid (the wrap).
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (!found && in_valid[c] && (RR_MODE != 0) && (c >= int'(rr_ptr_q))) begin
        found = 1'b1;
        gsel  = SEL_W'(c);
      end
    end
    for (int c = 0; c < NUM_IN; c++) begin
      if (!found && in_valid[c]) begin
        found = 1'b1;
        gsel  = SEL_W'(c);
      end
    end
  end

  always_comb begin
    grant = '0;
    gdata = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (found && (gsel == SEL_W'(c))) begin
        grant[c] = 1'b1;
        gdata    = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = gdata;
        out_sel_d  = gsel;
        if (RR_MODE != 0) begin
          rr_ptr_d = (gsel == SEL_W'(NUM_IN - 1)) ? '0 : gsel + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
